fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 10 +
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bus between fetch unit and imem
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with stall buffer, redirect kill and optional FETCH_ALIGN_CHECK_EN trap
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   fetch_unit_if.master      imem,
   output logic [31:0]       inst,
   output logic [31:0]       pc_increase_result,
   output logic              inst_valid,
   output logic              fetch_misalign
);

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [1:0] {FETCH, BUF, KILL, ERR} state_t;
`else
   typedef enum logic [1:0] {FETCH, BUF, KILL} state_t;
`endif

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] kill_addr, kill_n;
   logic [31:0] buf_inst, buf_inst_n;
   logic [31:0] buf_pc4, buf_pc4_n;
   logic [31:0] inst_n, pc4_n;
   logic        valid_n;
   logic        req;
   logic [31:0] addr;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc + 32'd4;

   // No request may reach the memory while reset holds the pipeline.
   assign imem.imem_req  = req & ~rst;
   assign imem.imem_addr = addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= FETCH;
         pc                 <= RESET_PC;
         kill_addr          <= 32'd0;
         buf_inst           <= 32'd0;
         buf_pc4            <= 32'd0;
         inst               <= 32'd0;
         pc_increase_result <= 32'd0;
         inst_valid         <= 1'b0;
      end else begin
         state              <= state_n;
         pc                 <= pc_n;
         kill_addr          <= kill_n;
         buf_inst           <= buf_inst_n;
         buf_pc4            <= buf_pc4_n;
         inst               <= inst_n;
         pc_increase_result <= pc4_n;
         inst_valid         <= valid_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      kill_n     = kill_addr;
      buf_inst_n = buf_inst;
      buf_pc4_n  = buf_pc4;
      inst_n     = inst;
      pc4_n      = pc_increase_result;
      valid_n    = inst_valid;
      req        = 1'b0;
      addr       = {pc[31:2], 2'b00};
      case (state)
         FETCH: begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (pc[1:0] != 2'b00) begin
               if (redirect) pc_n = redirect_pc;
               else          state_n = ERR;
               if (redirect || !hold) begin
                  inst_n  = 32'd0;
                  valid_n = 1'b0;
               end
            end else
`endif
            begin
               req = 1'b1;
               if (imem.imem_ready) begin
                  if (redirect) begin
                     pc_n    = redirect_pc;
                     inst_n  = 32'd0;
                     valid_n = 1'b0;
                  end else if (!hold) begin
                     inst_n  = imem.imem_rdata;
                     pc4_n   = pc_plus4;
                     valid_n = 1'b1;
                     pc_n    = pc_plus4;
                  end else begin
                     buf_inst_n = imem.imem_rdata;
                     buf_pc4_n  = pc_plus4;
                     pc_n       = pc_plus4;
                     state_n    = BUF;
                  end
               end else begin
                  if (redirect) begin
                     kill_n  = pc;
                     pc_n    = redirect_pc;
                     state_n = KILL;
                  end
                  if (redirect || !hold) begin
                     inst_n  = 32'd0;
                     valid_n = 1'b0;
                  end
               end
            end
         end
         BUF: begin
            if (redirect) begin
               pc_n    = redirect_pc;
               inst_n  = 32'd0;
               valid_n = 1'b0;
               state_n = FETCH;
            end else if (!hold) begin
               inst_n  = buf_inst;
               pc4_n   = buf_pc4;
               valid_n = 1'b1;
               state_n = FETCH;
            end
         end
         KILL: begin
            // The abandoned transfer must still finish before the new target is requested.
            req  = 1'b1;
            addr = {kill_addr[31:2], 2'b00};
            if (redirect) pc_n = redirect_pc;
            if (imem.imem_ready) state_n = FETCH;
            if (redirect || !hold) begin
               inst_n  = 32'd0;
               valid_n = 1'b0;
            end
         end
`ifdef FETCH_ALIGN_CHECK_EN
         ERR: begin
            inst_n  = 32'd0;
            valid_n = 1'b0;
            if (redirect) begin
               pc_n    = redirect_pc;
               state_n = FETCH;
            end
         end
`endif
         default: state_n = FETCH;
      endcase
   end

`ifdef FETCH_ALIGN_CHECK_EN
   assign fetch_misalign = (state == ERR);
`else
   assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        hold;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ready_drv;
   logic [31:0] inst;
   logic [31:0] pc_increase_result;
   logic        inst_valid;
   logic        fetch_misalign;
   int          checks = 0;
   int          failures = 0;

   fetch_unit_if imem_bus ();

   assign imem_bus.imem_ready = ready_drv;
   assign imem_bus.imem_rdata = imem_bus.imem_addr ^ 32'hA5A5_0000;

   fetch_unit dut (
      .clk                (clk),
      .rst                (rst),
      .hold               (hold),
      .redirect           (redirect),
      .redirect_pc        (redirect_pc),
      .imem               (imem_bus),
      .inst               (inst),
      .pc_increase_result (pc_increase_result),
      .inst_valid         (inst_valid),
      .fetch_misalign     (fetch_misalign)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; ready_drv = 1'b0;
      tick(); tick();
      checks++; if (inst !== 32'd0) begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst, 32'd0); end
      checks++; if (pc_increase_result !== 32'd0) begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", pc_increase_result, 32'd0); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
      checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", fetch_misalign); end
      checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_bus.imem_req); end
      rst = 1'b0;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_bus.imem_req); end
      checks++; if (imem_bus.imem_addr !== 32'h0) begin failures++; $display("FAIL first_addr got=%h exp=%h", imem_bus.imem_addr, 32'h0); end
   endtask

   task automatic test_stream();
      logic [31:0] a;
      ready_drv = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         a = 32'(k * 4);
         checks++; if (inst !== (a ^ 32'hA5A5_0000)) begin failures++; $display("FAIL stream_inst k=%0d got=%h exp=%h", k, inst, a ^ 32'hA5A5_0000); end
         checks++; if (pc_increase_result !== a + 32'd4) begin failures++; $display("FAIL stream_pc4 k=%0d got=%h exp=%h", k, pc_increase_result, a + 32'd4); end
         checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, inst_valid); end
      end
      checks++; if (imem_bus.imem_addr !== 32'h10) begin failures++; $display("FAIL stream_next_addr got=%h exp=%h", imem_bus.imem_addr, 32'h10); end
   endtask

   task automatic test_hold();
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL hold_req k=%0d got=%b exp=0", k, imem_bus.imem_req); end
         checks++; if (inst !== 32'hA5A5_000C) begin failures++; $display("FAIL hold_inst k=%0d got=%h exp=%h", k, inst, 32'hA5A5_000C); end
         checks++; if (pc_increase_result !== 32'h10) begin failures++; $display("FAIL hold_pc4 k=%0d got=%h exp=%h", k, pc_increase_result, 32'h10); end
      end
      hold = 1'b0;
      tick();
      checks++; if (inst !== 32'hA5A5_0010) begin failures++; $display("FAIL release_inst got=%h exp=%h", inst, 32'hA5A5_0010); end
      checks++; if (pc_increase_result !== 32'h14) begin failures++; $display("FAIL release_pc4 got=%h exp=%h", pc_increase_result, 32'h14); end
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL release_valid got=%b exp=1", inst_valid); end
      checks++; if (imem_bus.imem_addr !== 32'h14 || imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL release_addr got=%h req=%b exp=%h", imem_bus.imem_addr, imem_bus.imem_req, 32'h14); end
      tick();
      checks++; if (inst !== 32'hA5A5_0014) begin failures++; $display("FAIL after_hold_inst got=%h exp=%h", inst, 32'hA5A5_0014); end
   endtask

   task automatic test_kill();
      tick(); tick();
      ready_drv = 1'b0;
      #1;
      checks++; if (imem_bus.imem_addr !== 32'h20) begin failures++; $display("FAIL kill_pre_addr got=%h exp=%h", imem_bus.imem_addr, 32'h20); end
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL kill_valid got=%b exp=0", inst_valid); end
      checks++; if (imem_bus.imem_addr !== 32'h20 || imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL kill_hold_addr1 got=%h req=%b exp=%h", imem_bus.imem_addr, imem_bus.imem_req, 32'h20); end
      tick();
      checks++; if (imem_bus.imem_addr !== 32'h20) begin failures++; $display("FAIL kill_hold_addr2 got=%h exp=%h", imem_bus.imem_addr, 32'h20); end
      ready_drv = 1'b1;
      tick();
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL kill_drop_valid got=%b exp=0", inst_valid); end
      checks++; if (imem_bus.imem_addr !== 32'h100) begin failures++; $display("FAIL kill_next_addr got=%h exp=%h", imem_bus.imem_addr, 32'h100); end
      tick();
      checks++; if (inst !== 32'hA5A5_0100 || pc_increase_result !== 32'h104) begin failures++; $display("FAIL kill_target_inst got=%h/%h exp=%h/%h", inst, pc_increase_result, 32'hA5A5_0100, 32'h104); end
   endtask

   task automatic test_same_cycle();
      redirect = 1'b1; redirect_pc = 32'h40;
      tick();
      checks++; if (imem_bus.imem_addr !== 32'h40) begin failures++; $display("FAIL same_addr40 got=%h exp=%h", imem_bus.imem_addr, 32'h40); end
      redirect_pc = 32'h80;
      tick();
      checks++; if (inst_valid !== 1'b0 || inst !== 32'd0) begin failures++; $display("FAIL same_bubble got=%h/%b exp=0/0", inst, inst_valid); end
      checks++; if (imem_bus.imem_addr !== 32'h80) begin failures++; $display("FAIL same_next_addr got=%h exp=%h", imem_bus.imem_addr, 32'h80); end
      redirect = 1'b0;
      tick();
      checks++; if (inst !== 32'hA5A5_0080 || pc_increase_result !== 32'h84) begin failures++; $display("FAIL same_target got=%h/%h exp=%h/%h", inst, pc_increase_result, 32'hA5A5_0080, 32'h84); end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      tick();
      checks++; if (inst !== 32'h5A5A_FFFC) begin failures++; $display("FAIL wrap_inst got=%h exp=%h", inst, 32'h5A5A_FFFC); end
      checks++; if (pc_increase_result !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=%h", pc_increase_result, 32'h0); end
      checks++; if (imem_bus.imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=%h", imem_bus.imem_addr, 32'h0); end
   endtask

   task automatic test_buf_redirect();
      hold = 1'b1;
      tick();
      redirect = 1'b1; redirect_pc = 32'h300;
      tick();
      redirect = 1'b0; hold = 1'b0;
      #1;
      checks++; if (inst_valid !== 1'b0 || inst !== 32'd0) begin failures++; $display("FAIL bufred_bubble got=%h/%b exp=0/0", inst, inst_valid); end
      checks++; if (pc_increase_result !== 32'h0) begin failures++; $display("FAIL bufred_pc4 got=%h exp=%h", pc_increase_result, 32'h0); end
      checks++; if (imem_bus.imem_addr !== 32'h300 || imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL bufred_addr got=%h req=%b exp=%h", imem_bus.imem_addr, imem_bus.imem_req, 32'h300); end
   endtask

   task automatic test_hold_nodeliver();
      tick();
      ready_drv = 1'b0; hold = 1'b1;
      tick();
      checks++; if (inst !== 32'hA5A5_0300 || inst_valid !== 1'b1) begin failures++; $display("FAIL holdwait_keep got=%h/%b exp=%h/1", inst, inst_valid, 32'hA5A5_0300); end
      hold = 1'b0;
      tick();
      checks++; if (inst !== 32'd0 || inst_valid !== 1'b0) begin failures++; $display("FAIL wait_bubble got=%h/%b exp=0/0", inst, inst_valid); end
      checks++; if (pc_increase_result !== 32'h304) begin failures++; $display("FAIL wait_pc4 got=%h exp=%h", pc_increase_result, 32'h304); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b0 || inst_valid !== 1'b0 || pc_increase_result !== 32'd0) begin failures++; $display("FAIL midrst_outputs got req=%b valid=%b pc4=%h exp 0", imem_bus.imem_req, inst_valid, pc_increase_result); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin failures++; $display("FAIL midrst_req got=%b addr=%h exp=1/%h", imem_bus.imem_req, imem_bus.imem_addr, 32'h0); end
   endtask

   task automatic test_misalign();
      ready_drv = 1'b1; redirect = 1'b1; redirect_pc = 32'h102;
      tick();
      redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      ready_drv = 1'b0;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", imem_bus.imem_req); end
      tick();
      checks++; if (fetch_misalign !== 1'b1 || imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL mis_err got=%b req=%b exp=1/0", fetch_misalign, imem_bus.imem_req); end
      tick();
      checks++; if (fetch_misalign !== 1'b1 || inst_valid !== 1'b0) begin failures++; $display("FAIL mis_sticky got=%b valid=%b exp=1/0", fetch_misalign, inst_valid); end
      redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      redirect = 1'b0; ready_drv = 1'b1;
      #1;
      checks++; if (fetch_misalign !== 1'b0 || imem_bus.imem_addr !== 32'h200 || imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL mis_clear got=%b addr=%h req=%b exp=0/%h/1", fetch_misalign, imem_bus.imem_addr, imem_bus.imem_req, 32'h200); end
      tick();
      checks++; if (inst !== 32'hA5A5_0200) begin failures++; $display("FAIL mis_fetch got=%h exp=%h", inst, 32'hA5A5_0200); end
`else
      #1;
      checks++; if (imem_bus.imem_addr !== 32'h100 || imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL noalign_addr got=%h req=%b exp=%h/1", imem_bus.imem_addr, imem_bus.imem_req, 32'h100); end
      tick();
      checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL noalign_flag got=%b exp=0", fetch_misalign); end
      checks++; if (inst !== 32'hA5A5_0100 || pc_increase_result !== 32'h106) begin failures++; $display("FAIL noalign_inst got=%h/%h exp=%h/%h", inst, pc_increase_result, 32'hA5A5_0100, 32'h106); end
`endif
   endtask

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_kill();
      test_same_cycle();
      test_wrap();
      test_buf_redirect();
      test_hold_nodeliver();
      test_reset_mid();
      test_misalign();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
